// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the sequencer state encoding, data-space base and SRAM address width.
package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_LO = 2'd1,
        ST_ACC_HI = 2'd2,
        ST_DONE   = 2'd3
    } sram_state_t;

    localparam logic [31:0] DATA_BASE_ADDR = 32'd1024;
    localparam int          SRAM_AW        = 18;

    // Halfword address of one half of a 32-bit word in SRAM space.
    function automatic logic [SRAM_AW-1:0] hw_addr(input logic [SRAM_AW-2:0] word,
                                                  input logic             hi);
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Sequences a 32-bit load/store as two 16-bit SRAM phases with wait states,
// holding ready low (pipeline freeze) for the whole access.
module sram_controller
    import arm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDR,
    parameter int          STEP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int               CNT_W      = $clog2(STEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    sram_state_t        state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               is_wr_r;
    logic [SRAM_AW-2:0] word_r;
    logic [31:0]        wdata_r;
    logic [31:0]        rdata_r;

    logic               req_s;
    logic [31:0]        offset_s;
    logic               unused_offset_bits_s;
    logic [SRAM_AW-2:0] word_s;
    logic               is_wr_s;
    logic [31:0]        wdata_s;
    logic               ready_s;

    logic [SRAM_AW-1:0] sram_addr_r, sram_addr_s;
    logic               we_n_r, we_n_s;
    logic               dq_oe_r, dq_oe_s;
    logic [15:0]        dq_out_r, dq_out_s;

    assign req_s    = wr_en | rd_en;
    assign offset_s = address - BASE_ADDR;
    assign unused_offset_bits_s = ^{offset_s[31:19], offset_s[1:0]};

    // State, counter, captured request, read data and registered SRAM pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            is_wr_r     <= 1'b0;
            word_r      <= {(SRAM_AW-1){1'b0}};
            wdata_r     <= 32'd0;
            rdata_r     <= 32'd0;
            sram_addr_r <= {SRAM_AW{1'b0}};
            we_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            is_wr_r     <= is_wr_s;
            word_r      <= word_s;
            wdata_r     <= wdata_s;
            sram_addr_r <= sram_addr_s;
            we_n_r      <= we_n_s;
            dq_oe_r     <= dq_oe_s;
            dq_out_r    <= dq_out_s;
            // Loads latch each halfword on the last wait-state cycle of its phase.
            if (!is_wr_r && (cnt_r == CNT_ZERO) && (state_r == ST_ACC_LO)) begin
                rdata_r[15:0] <= SRAM_DQ;
            end else if (!is_wr_r && (cnt_r == CNT_ZERO) && (state_r == ST_ACC_HI)) begin
                rdata_r[31:16] <= SRAM_DQ;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Next-state and wait-state counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_s = ST_ACC_LO;
                    cnt_s   = CNT_RELOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC_LO: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_ACC_HI;
                    cnt_s   = CNT_RELOAD;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ACC_HI: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Ready and the SRAM pin values for the state being entered.
    always_comb begin
        ready_s     = 1'b0;
        word_s      = word_r;
        is_wr_s     = is_wr_r;
        wdata_s     = wdata_r;
        sram_addr_s = sram_addr_r;
        we_n_s      = 1'b1;
        dq_oe_s     = 1'b0;
        dq_out_s    = 16'd0;

        if (state_r == ST_IDLE) begin
            ready_s = ~req_s;
            if (req_s) begin
                word_s  = offset_s[SRAM_AW:2];
                is_wr_s = wr_en;
                wdata_s = writeData;
            end else begin
                word_s = word_r;
            end
        end else begin
            ready_s = (state_r == ST_DONE);
        end

        case (state_s)
            ST_ACC_LO: begin
                sram_addr_s = hw_addr(word_s, 1'b0);
                we_n_s      = ~is_wr_s;
                dq_oe_s     = is_wr_s;
                dq_out_s    = wdata_s[15:0];
            end
            ST_ACC_HI: begin
                sram_addr_s = hw_addr(word_s, 1'b1);
                we_n_s      = ~is_wr_s;
                dq_oe_s     = is_wr_s;
                dq_out_s    = wdata_s[31:16];
            end
            default: begin
                we_n_s  = 1'b1;
                dq_oe_s = 1'b0;
            end
        endcase
    end

    assign ready     = ready_s;
    assign readData  = rdata_r;
    assign SRAM_ADDR = sram_addr_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule
